// File: rtl/sc_ulpi_utx.sv
// ULPI link-side transmit engine: packet transmit (TX CMD + data + STP) and
// immediate register write/read, with PHY-driven DIR turnaround handling.
module sc_ulpi_utx (
    input  logic       ULPICLK,
    input  logic       ULPIRSTB,
    input  logic       ULPI_DIR,
    input  logic       ULPI_NXT,
    input  logic [7:0] ULPI_DATA_IN,
    output logic [7:0] ULPI_DATA_OUT,
    output logic       ULPI_DATA_OE,
    output logic       ULPI_STP,
    input  logic       TX_VALID,
    input  logic [7:0] TX_DATA,
    input  logic       TX_LAST,
    output logic       TX_READY,
    output logic       TX_DONE,
    output logic       TX_ABORT,
    input  logic       REG_REQ,
    input  logic       REG_WE,
    input  logic [5:0] REG_ADDR,
    input  logic [7:0] REG_WDATA,
    output logic       REG_ACK,
    output logic       REG_ERR,
    output logic [7:0] REG_RDATA
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_TXCMD  = 4'd1;
    localparam logic [3:0] S_TXDATA = 4'd2;
    localparam logic [3:0] S_TXSTP  = 4'd3;
    localparam logic [3:0] S_RWCMD  = 4'd4;
    localparam logic [3:0] S_RWDATA = 4'd5;
    localparam logic [3:0] S_RWSTP  = 4'd6;
    localparam logic [3:0] S_RRCMD  = 4'd7;
    localparam logic [3:0] S_RRTURN = 4'd8;
    localparam logic [3:0] S_RRDATA = 4'd9;
    localparam logic [3:0] S_RRWAIT = 4'd10;

    logic [3:0] r_state;
    logic       r_dir_1p;
    logic [7:0] r_data_out;
    logic       r_stp;
    logic       r_last;
    logic       r_tx_done;
    logic       r_tx_abort;
    logic       r_reg_ack;
    logic       r_reg_err;
    logic [7:0] r_reg_rdata;

    logic       w_bus_free;
    logic       w_tx_ready;

    // Bus is ours only when DIR is low now and was low last cycle (turnaround).
    assign w_bus_free = !ULPI_DIR && !r_dir_1p;

    always_comb begin
        w_tx_ready = 1'b0;
        case (r_state)
            S_IDLE:            w_tx_ready = w_bus_free && !REG_REQ;
            S_TXCMD, S_TXDATA: w_tx_ready = ULPI_NXT && !r_last;
            default:           w_tx_ready = 1'b0;
        endcase
    end

    assign ULPI_DATA_OE  = w_bus_free;
    assign ULPI_DATA_OUT = r_data_out;
    assign ULPI_STP      = r_stp;
    assign TX_READY      = w_tx_ready;
    assign TX_DONE       = r_tx_done;
    assign TX_ABORT      = r_tx_abort;
    assign REG_ACK       = r_reg_ack;
    assign REG_ERR       = r_reg_err;
    assign REG_RDATA     = r_reg_rdata;

    always_ff @(posedge ULPICLK or negedge ULPIRSTB) begin
        if (!ULPIRSTB) begin
            r_state     <= S_IDLE;
            r_dir_1p    <= 1'b1;
            r_data_out  <= '0;
            r_stp       <= 1'b0;
            r_last      <= 1'b0;
            r_tx_done   <= 1'b0;
            r_tx_abort  <= 1'b0;
            r_reg_ack   <= 1'b0;
            r_reg_err   <= 1'b0;
            r_reg_rdata <= '0;
        end else begin
            r_dir_1p   <= ULPI_DIR;
            r_stp      <= 1'b0;
            r_tx_done  <= 1'b0;
            r_tx_abort <= 1'b0;
            r_reg_ack  <= 1'b0;
            r_reg_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_data_out <= '0;
                    if (w_bus_free) begin
                        if (REG_REQ) begin
                            r_state    <= REG_WE ? S_RWCMD : S_RRCMD;
                            r_data_out <= {REG_WE ? 2'b10 : 2'b11, REG_ADDR};
                        end else if (TX_VALID) begin
                            r_state    <= S_TXCMD;
                            r_data_out <= {4'b0100, TX_DATA[3:0]};
                            r_last     <= TX_LAST;
                        end
                    end
                end
                S_TXCMD, S_TXDATA: begin
                    // r_data_out doubles as the hold register for the byte on the bus.
                    if (ULPI_DIR) begin
                        r_tx_abort <= 1'b1;
                        r_data_out <= '0;
                        r_state    <= S_IDLE;
                    end else if (ULPI_NXT) begin
                        if (r_last) begin
                            r_state    <= S_TXSTP;
                            r_stp      <= 1'b1;
                            r_data_out <= '0;
                            r_tx_done  <= 1'b1;
                        end else if (TX_VALID) begin
                            r_state    <= S_TXDATA;
                            r_data_out <= TX_DATA;
                            r_last     <= TX_LAST;
                        end else begin
                            r_state    <= S_TXSTP;
                            r_stp      <= 1'b1;
                            r_data_out <= '1;
                            r_tx_abort <= 1'b1;
                        end
                    end
                end
                S_TXSTP, S_RWSTP: begin
                    r_data_out <= '0;
                    r_state    <= S_IDLE;
                end
                S_RWCMD, S_RWDATA, S_RRCMD: begin
                    if (ULPI_DIR) begin
                        r_reg_ack  <= 1'b1;
                        r_reg_err  <= 1'b1;
                        r_data_out <= '0;
                        r_state    <= S_RRWAIT;
                    end else if (ULPI_NXT) begin
                        if (r_state == S_RWCMD) begin
                            r_state    <= S_RWDATA;
                            r_data_out <= REG_WDATA;
                        end else if (r_state == S_RWDATA) begin
                            r_state    <= S_RWSTP;
                            r_stp      <= 1'b1;
                            r_data_out <= '0;
                            r_reg_ack  <= 1'b1;
                        end else begin
                            r_state    <= S_RRTURN;
                            r_data_out <= '0;
                        end
                    end
                end
                S_RRTURN: begin
                    if (!ULPI_DIR) begin
                        r_reg_ack <= 1'b1;
                        r_reg_err <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_state <= S_RRDATA;
                    end
                end
                S_RRDATA: begin
                    r_reg_rdata <= ULPI_DATA_IN;
                    r_reg_ack   <= 1'b1;
                    r_state     <= S_RRWAIT;
                end
                S_RRWAIT: begin
                    if (!ULPI_DIR) r_state <= S_IDLE;
                end
                default: begin
                    r_data_out <= '0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sc_ulpi_utx.md
SC_ULPI_UTX -- requirements
Module: sc_ulpi_utx

Interface
REQ-001 SHALL have one clock, ULPICLK; reset is asynchronous and active-low, ULPIRSTB.
REQ-002 SHALL have the following ports (name, direction, width, meaning), clock and reset first:
  - ULPICLK  in  1  60 MHz ULPI clock from the PHY
  - ULPIRSTB  in  1  async active-low reset
  - ULPI_DIR  in  1  PHY bus direction; 1 = PHY owns bus
  - ULPI_NXT  in  1  PHY throttle; byte on bus accepted this cycle
  - ULPI_DATA_IN  in  8  bus data from PHY
  - ULPI_DATA_OUT  out  8  bus data to PHY
  - ULPI_DATA_OE  out  1  link drives bus
  - ULPI_STP  out  1  link stop
  - TX_VALID  in  1  packet byte valid
  - TX_DATA  in  8  packet byte; first byte of packet = PID
  - TX_LAST  in  1  final byte of packet
  - TX_READY  out  1  byte taken when TX_VALID & TX_READY
  - TX_DONE  out  1  1-cycle pulse, packet completed
  - TX_ABORT  out  1  1-cycle pulse, packet aborted
  - REG_REQ  in  1  register access request, held until REG_ACK
  - REG_WE  in  1  1 = RegWrite, 0 = RegRead
  - REG_ADDR  in  6  immediate register address
  - REG_WDATA  in  8  write data
  - REG_ACK  out  1  1-cycle pulse, access finished
  - REG_ERR  out  1  valid with REG_ACK; access aborted by DIR
  - REG_RDATA  out  8  read data, valid with REG_ACK, held until next read

Function
REQ-003 SHALL implement states IDLE, TXCMD, TXDATA, TXSTP, RWCMD, RWDATA, RWSTP, RRCMD, RRTURN, RRDATA, RRWAIT.
REQ-004 SHALL register ULPI_DIR each cycle (dir_1p); ULPI_DATA_OE = !ULPI_DIR & !dir_1p, combinational; turnaround cycles are never driven.
REQ-005 SHALL drive ULPI_DATA_OUT = 8'h00 and ULPI_STP = 0 in IDLE.
REQ-006 SHALL leave IDLE only when ULPI_DIR = 0 and dir_1p = 0; REG_REQ has priority over TX_VALID when both are pending.
REQ-007 Packet start: SHALL assert TX_READY in IDLE when starting; SHALL capture the PID byte, then go to TXCMD driving {2'b01, 2'b00, PID[3:0]}.
REQ-008 TXCMD/TXDATA: SHALL hold the current byte until ULPI_NXT = 1; TX_READY = ULPI_NXT & !last_held, combinational.
REQ-009 On NXT with the held byte marked last (including PID-only packets): SHALL go to TXSTP.
REQ-010 On NXT with the held byte not last: if TX_VALID, SHALL load TX_DATA into the hold register and go/stay TXDATA; if !TX_VALID (underrun), SHALL go to TXSTP with error flag set.
REQ-011 TXSTP: SHALL assert ULPI_STP for exactly 1 cycle with ULPI_DATA_OUT = 8'h00 (normal) or 8'hFF (underrun); then IDLE.
REQ-012 Packet outcome pulses, asserted in the TXSTP cycle: TX_DONE on a normal end; TX_ABORT on underrun.
REQ-013 ULPI_DIR = 1 in TXCMD or TXDATA: SHALL pulse TX_ABORT, stop driving, go IDLE, without asserting STP.
REQ-014 RegWrite, RWCMD: SHALL drive {2'b10, REG_ADDR}; on NXT go to RWDATA.
REQ-015 RegWrite, RWDATA: SHALL drive REG_WDATA; on NXT go to RWSTP.
REQ-016 RegWrite, RWSTP: SHALL assert STP with data 00 for 1 cycle and pulse REG_ACK (REG_ERR = 0); then IDLE.
REQ-017 RegRead, RRCMD: SHALL drive {2'b11, REG_ADDR}; on NXT go to RRTURN.
REQ-018 RegRead, RRTURN (DIR expected 1): SHALL go to RRDATA.
REQ-019 RegRead, RRDATA: SHALL capture ULPI_DATA_IN into REG_RDATA and pulse REG_ACK; then RRWAIT until ULPI_DIR = 0, then IDLE.
REQ-020 ULPI_DIR = 1 in RWCMD, RWDATA, or RRCMD before NXT: SHALL pulse REG_ACK with REG_ERR = 1 and go to RRWAIT; REG_RDATA is unchanged.
REQ-021 ULPI_DIR = 0 in RRTURN: SHALL pulse REG_ACK with REG_ERR = 1, then IDLE.
REQ-022 SHALL sample TX_LAST only on accepted bytes; TX_VALID/TX_DATA are ignored outside TX_READY.
REQ-023 All outputs except ULPI_DATA_OE and TX_READY SHALL be registered.

Reset
REQ-024 While ULPIRSTB = 0, the block SHALL hold: state = IDLE; ULPI_DATA_OUT = 8'h00; ULPI_STP = 0; TX_DONE = 0; TX_ABORT = 0; REG_ACK = 0; REG_ERR = 0; REG_RDATA = 8'h00; dir_1p = 1 (no drive in the first cycle after release).
REQ-025 Reset asserted mid-transfer SHALL abandon the transfer with no STP and no ack pulse.

Verification
REQ-026 RegWrite, addr 0x0A, data 0x45, NXT on the 2nd cycle of each phase -> bus shows 0x8A, 0x45, then STP = 1 with 0x00; REG_ACK = 1, REG_ERR = 0.
REQ-027 RegRead, addr 0x00; PHY raises DIR after NXT and returns 0x24 -> bus shows 0xC0; OE drops during turnaround; REG_RDATA = 0x24 with REG_ACK.
REQ-028 Packet {0xC3, 0x11, 0x22 last}, NXT always 1 -> bus shows 0x43, 0x11, 0x22, then STP with 0x00; TX_DONE = 1, 3 bytes accepted.
REQ-029 Packet {0xE1, 0x55, ...} with TX_VALID low after 0x55 is accepted -> STP with 0xFF; TX_ABORT = 1, TX_DONE = 0.
REQ-030 DIR rises during TXDATA -> OE = 0 the same cycle, TX_ABORT pulse, STP never asserted; a subsequent REG_REQ is served only after 2 DIR-low cycles.
REQ-031 REG_REQ and TX_VALID raised in the same cycle -> register access completes first, then the packet; reset pulse during TXDATA -> outputs reach reset values immediately.
